inst_queue: RTL and testbench
=============================

# inst_queue

Parametrised instruction buffer for the multi-cycle RISC-V core. It generalises the single instruction register into a DEPTH-entry FIFO between instruction memory and the control/decode logic, using a valid/ready handshake on both sides and a flush for redirects. The head entry is presented to the datapath with its rs1, rs2, rd and opcode fields already split out.

## Interface
Parameters:
- BUS_WIDTH, 32: instruction width. Must be at least 32, because the field slices below assume RV32 encoding.
- DEPTH, 4: number of entries. Must be a power of two and at least 2.
- REGISTER_INDEX_WIDTH, 5: width of the register index fields.

Ports:
- clk  input  1  clock. All state updates on the falling edge.
- rst  input  1  reset. Asynchronous, active-high.
- inst_in  input  BUS_WIDTH  instruction word from memory.
- in_valid  input  1  inst_in is valid this cycle.
- in_ready  output  1  queue can accept an entry. Equals not full.
- flush  input  1  discard all entries (branch/jump redirect).
- out_ready  input  1  consumer takes the head entry this cycle.
- out_valid  output  1  head entry is valid. Equals not empty.
- inst_out  output  BUS_WIDTH  head instruction. Reads 0 when empty.
- reg1  output  REGISTER_INDEX_WIDTH  inst_out[19:15].
- reg2  output  REGISTER_INDEX_WIDTH  inst_out[24:20].
- dest  output  REGISTER_INDEX_WIDTH  inst_out[11:7].
- opcode  output  7  inst_out[6:0].
- count  output  clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage is a DEPTH x BUS_WIDTH array with write pointer wr_ptr, read pointer rd_ptr (each clog2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter.
- push = in_valid & in_ready. On push, store inst_in at wr_ptr and increment wr_ptr.
- pop = out_ready & out_valid. On pop, increment rd_ptr.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Outputs are combinational from rd_ptr. The fields are slices of inst_out, so all of them read 0 when empty.
- Edge priority, highest first:
  - rst: pointers and count go to 0. Storage is not cleared.
  - flush: pointers and count go to 0. A push or pop in the same cycle is dropped.
  - push and/or pop, as above.
- Boundary conditions:
  - Full (count == DEPTH): in_ready = 0, so no push occurs. A pop in that cycle still occurs. A new word is accepted on the following edge.
  - Empty: out_valid = 0 and out_ready is ignored. A push in that cycle occurs, and the entry appears at the head after the edge.
  - Wrap: pointers roll from DEPTH-1 to 0 with no loss of ordering.
- Reset mid-operation: all entries are discarded immediately, without waiting for a clock edge.

## Timing
- Reset values: out_valid 0, in_ready 1, count 0, inst_out/reg1/reg2/dest/opcode 0.
- Latency: a word pushed into an empty queue on falling edge N is visible on inst_out right after edge N. It can be popped at edge N+1.
- Throughput: one push and one pop per edge.
- in_ready, out_valid and count change only on a falling edge or on rst assertion.
- No combinational path from any input to in_ready or out_valid.
- Flush at edge N: out_valid = 0 and in_ready = 1 right after edge N.

## Test plan
- Reset: hold rst with in_valid = 1, then release -> out_valid 0, count 0, inst_out 0, in_ready 1.
- Decode: push 0x00B50533 (add x10,x10,x11) into an empty queue -> after one edge, out_valid 1, reg1 10, reg2 11, dest 10, opcode 0x33.
- Fill/full: DEPTH=4, push 0x11, 0x22, 0x33, 0x44, then present 0x55 -> count 4, in_ready 0, 0x55 not stored. Pop one -> head 0x22, in_ready 1 after the edge.
- Wrap and simultaneous: stream 10 words with in_valid and out_ready both held at 1 -> words come out in order, with count constant at 1 after the first edge.
- Flush priority: with 3 entries, assert flush together with in_valid (word 0x99) and out_ready -> count 0, out_valid 0, 0x99 never appears.
- Async reset mid-stream: assert rst between edges with 2 entries -> out_valid falls with no clock edge, inst_out reads 0.

Source files
------------

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - DEPTH-entry instruction FIFO with RV32 field decode at the head
module inst_queue #(
  parameter int BUS_WIDTH            = 32,
  parameter int DEPTH                = 4,
  parameter int REGISTER_INDEX_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BUS_WIDTH-1:0]            inst_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            flush,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [BUS_WIDTH-1:0]            inst_out,
  output logic [REGISTER_INDEX_WIDTH-1:0] reg1,
  output logic [REGISTER_INDEX_WIDTH-1:0] reg2,
  output logic [REGISTER_INDEX_WIDTH-1:0] dest,
  output logic [6:0]                      opcode,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;

  // Handshake flags derive only from the registered count, so no input reaches them.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_ready & out_valid;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; the count alone decides validity.
  always_ff @(negedge clk) begin
    if (push && !flush) mem[wr_ptr] <= inst_in;
  end

  assign inst_out = out_valid ? mem[rd_ptr] : '0;
  assign reg1     = REGISTER_INDEX_WIDTH'(inst_out[19:15]);
  assign reg2     = REGISTER_INDEX_WIDTH'(inst_out[24:20]);
  assign dest     = REGISTER_INDEX_WIDTH'(inst_out[11:7]);
  assign opcode   = inst_out[6:0];

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] inst_out;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic [4:0]  dest;
  logic [6:0]  opcode;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  inst_queue #(
    .BUS_WIDTH(32),
    .DEPTH(4),
    .REGISTER_INDEX_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inst_in(inst_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .inst_out(inst_out),
    .reg1(reg1),
    .reg2(reg2),
    .dest(dest),
    .opcode(opcode),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance past the next falling (active) edge and settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    inst_in  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_word();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [31:0] stream [10];

  initial begin
    // Reset held while in_valid is asserted
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    inst_in  = 32'hDEAD_BEEF;
    step();
    step();
    check("rst_hold_count", 32'(count), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_opcode", 32'(opcode), 32'd0);

    // Decode of add x10,x10,x11
    push_word(32'h00B5_0533);
    check("dec_out_valid", 32'(out_valid), 32'd1);
    check("dec_inst", inst_out, 32'h00B5_0533);
    check("dec_reg1", 32'(reg1), 32'd10);
    check("dec_reg2", 32'(reg2), 32'd11);
    check("dec_dest", 32'(dest), 32'd10);
    check("dec_opcode", 32'(opcode), 32'h33);
    pop_word();
    check("dec_pop_valid", 32'(out_valid), 32'd0);
    check("dec_pop_inst", inst_out, 32'h0);

    // Fill to full, offer one more, then pop
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    push_word(32'h44);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    push_word(32'h55);
    check("full_count_after_55", 32'(count), 32'd4);
    check("full_head", inst_out, 32'h11);
    pop_word();
    check("full_pop_head", inst_out, 32'h22);
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    check("full_pop_count", 32'(count), 32'd3);
    pop_word();
    check("drain_head_33", inst_out, 32'h33);
    pop_word();
    check("drain_head_44", inst_out, 32'h44);
    pop_word();
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Simultaneous push/pop stream across pointer wrap
    for (int i = 0; i < 10; i++) stream[i] = 32'h0000_0100 + 32'(i * 17);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inst_in = stream[i];
      step();
      check($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
      check($sformatf("stream_head_%0d", i), inst_out, stream[i]);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream_drained", 32'(count), 32'd0);

    // Flush beats simultaneous push and pop
    push_word(32'hA1);
    push_word(32'hA2);
    push_word(32'hA3);
    check("flush_pre_count", 32'(count), 32'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    inst_in   = 32'h99;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_inst_out", inst_out, 32'h0);
    push_word(32'h77);
    check("flush_next_head", inst_out, 32'h77);
    check("flush_next_count", 32'(count), 32'd1);
    pop_word();

    // Asynchronous reset between edges
    push_word(32'hB1);
    push_word(32'hB2);
    check("arst_pre_count", 32'(count), 32'd2);
    check("arst_pre_head", inst_out, 32'hB1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_inst_out", inst_out, 32'h0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();
    push_word(32'hC1);
    check("arst_next_head", inst_out, 32'hC1);
    check("arst_next_count", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
